// File: rtl/windower_pkg.sv
// Shared types and helpers for the windower feed path.
// No logic; pure declarations.
// Channel/bit widths of pixel_t can be overridden by defining the macros before compilation.
package windower_pkg;

`ifndef WINDOWER_CH_IN
`define WINDOWER_CH_IN 3
`endif
`ifndef WINDOWER_BW
`define WINDOWER_BW 16
`endif

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } feed_state_t;

  typedef logic [`WINDOWER_CH_IN-1:0][`WINDOWER_BW-1:0] pixel_t;

  // Pixels in one square frame of side n.
  function automatic int PIX_PER_FRAME(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Purpose: first-word-fall-through FIFO, DEPTH entries of W bits, with occupancy count.
// Latency: a pushed word is visible on rdata the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; callers gate on full/empty.
module sync_fifo_fwft #(
  parameter int W     = 48,
  parameter int DEPTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/windower_feed_ctrl.sv
// Purpose: buffers a bursty pixel stream and feeds each frame to the windower as one unbroken valid run.
// Latency: occupancy reaching START_LVL at edge N -> STREAM at N+1 -> first win_vld after N+2.
// Backpressure: s_rdy = FIFO not full; the windower side has none, so an empty FIFO mid-frame emits zeros.
module windower_feed_ctrl
  import windower_pkg::*;
#(
  parameter int IMG_SIZE   = 32,
  parameter int CH_IN      = 3,
  parameter int BW         = 16,
  parameter int DEPTH      = 64,
  parameter int START_LVL  = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_vld,
  output logic                s_rdy,
  input  logic [CH_IN*BW-1:0] s_data,
  output logic                win_vld,
  output logic [CH_IN*BW-1:0] win_data,
  input  logic                win_vld_out,
  output logic                frame_start,
  output logic                frame_done,
  output logic                underrun,
  output logic                vld_err,
  output logic                busy,
  input  logic                clr_err
);

  localparam int PIX      = PIX_PER_FRAME(IMG_SIZE);
  localparam int W        = CH_IN * BW;
  localparam int CW       = $clog2(PIX + 1);
  localparam int FCW      = $clog2(DEPTH + 1);
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  feed_state_t    state;
  logic [CW-1:0]  in_cnt;
  logic [CW-1:0]  out_cnt;
  logic [GW-1:0]  gap_cnt;

  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_cnt;
  logic [FCW-1:0] cnt_next;
  logic [W-1:0]   fifo_dout;
  logic           start_next;
  logic           underrun_set;
  logic           vld_drop;

  assign s_rdy = ~fifo_full;
  assign push  = s_vld & ~fifo_full;
  assign pop   = (state == STREAM);
  assign busy  = (state != IDLE);

  // Occupancy after this edge: lets a frame follow a gap (or another frame) with no extra IDLE cycle.
  assign cnt_next   = fifo_cnt + FCW'(push) - FCW'(pop & ~fifo_empty);
  assign start_next = (cnt_next >= FCW'(START_LVL));

  assign underrun_set = (state == STREAM) & fifo_empty;
  assign vld_drop     = ~win_vld_out & (out_cnt != '0);

  sync_fifo_fwft #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Feed sequencer with registered windower-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_cnt      <= '0;
      gap_cnt     <= '0;
      win_vld     <= 1'b0;
      win_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      win_vld     <= 1'b0;
      win_data    <= '0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_cnt >= FCW'(START_LVL)) state <= STREAM;
        end
        STREAM: begin
          // Valid is held even on an empty FIFO so the windower raster stays aligned.
          win_vld     <= 1'b1;
          win_data    <= fifo_empty ? '0 : fifo_dout;
          frame_start <= (in_cnt == '0);
          if (in_cnt == CW'(PIX - 1)) begin
            in_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else if (!start_next) begin
              state <= IDLE;
            end
          end else begin
            in_cnt <= in_cnt + CW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_LAST)) begin
            gap_cnt <= '0;
            state   <= start_next ? STREAM : IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output monitor: counts windower valids, pulses frame_done per frame, flags mid-frame drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (win_vld_out) begin
        if (out_cnt == CW'(PIX - 1)) begin
          out_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          out_cnt <= out_cnt + CW'(1);
        end
      end else if (vld_drop) begin
        out_cnt <= '0;
      end
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
      vld_err  <= 1'b0;
    end else begin
      underrun <= underrun_set | (underrun & ~clr_err);
      vld_err  <= vld_drop | (vld_err & ~clr_err);
    end
  end

endmodule
